// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if
//   Groups the serial lines and the word-level handshakes of the SPI
//   peripheral endpoint.
//   master modport: the side that drives chip select, shift qualifier and mosi,
//                   supplies transmit words and consumes received words.
//   slave modport : the spi_slave_port endpoint itself.
//   Signals: cs, shift_en, mosi, miso          serial side
//            tx_data, tx_load, tx_ready        transmit buffer handshake
//            rx_data, rx_valid, rx_ack         receive word handshake
//            overrun, busy                     status
interface spi_slave_port_if #(
  parameter int DATA_W = 8
);
  logic              cs;
  logic              shift_en;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              overrun;
  logic              busy;

  modport master (
    output cs, shift_en, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, overrun, busy
  );

  modport slave (
    input  cs, shift_en, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port
//   Peripheral-side SPI endpoint clocked by the master's sclk. While selected
//   (cs low) each qualified edge (shift_en high) samples mosi LSB-first and
//   drives the next transmit bit on miso. Completed words are presented on a
//   valid/ack port; the next transmit word comes from a single-entry buffer
//   loaded through a ready/load handshake.
//   Ports: sclk  - clock, rising edge
//          reset - asynchronous, active-low
//          bus   - spi_slave_port_if.slave (serial lines, tx/rx handshakes,
//                  overrun pulse, busy)
module spi_slave_port #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b0}}
) (
  input  logic             sclk,
  input  logic             reset,
  spi_slave_port_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] shift_reg_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] tx_buf_r;
  logic              miso_r;
  logic              tx_ready_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              overrun_r;
  logic              busy_r;

  logic              frame_start_s;
  logic [DATA_W-1:0] reload_word_s;

  // Frame start: selected while idle, or back-to-back from the one-cycle DONE.
  always_comb begin
    frame_start_s = 1'b0;
    if (!bus.cs && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      frame_start_s = 1'b1;
    end else begin
      frame_start_s = 1'b0;
    end
  end

  // Word loaded into the shifter at frame start: buffered word, else FILL.
  always_comb begin
    reload_word_s = FILL;
    if (tx_ready_r) begin
      reload_word_s = FILL;
    end else begin
      reload_word_s = tx_buf_r;
    end
  end

  // Frame FSM, shifter, tx buffer and rx handshake with registered outputs.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      shift_reg_r <= {DATA_W{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      tx_buf_r    <= {DATA_W{1'b0}};
      miso_r      <= 1'b0;
      tx_ready_r  <= 1'b1;
      rx_data_r   <= {DATA_W{1'b0}};
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      overrun_r <= 1'b0;

      // A frame start consumes a full buffer and blocks a same-edge load;
      // with the buffer empty the frame gets FILL and the load is captured.
      if (frame_start_s) begin
        shift_reg_r <= reload_word_s;
        bit_cnt_r   <= {CNT_W{1'b0}};
        if (!tx_ready_r) begin
          tx_ready_r <= 1'b1;
        end else if (bus.tx_load) begin
          tx_buf_r   <= bus.tx_data;
          tx_ready_r <= 1'b0;
        end
      end else if (bus.tx_load && tx_ready_r) begin
        tx_buf_r   <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end

      // The newly completed word always wins over a pending ack.
      if (state_r == ST_DONE) begin
        rx_data_r  <= shift_reg_r;
        rx_valid_r <= 1'b1;
        overrun_r  <= rx_valid_r & ~bus.rx_ack;
      end else if (rx_valid_r && bus.rx_ack) begin
        rx_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (!bus.cs) begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.cs) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (bus.shift_en) begin
            miso_r      <= shift_reg_r[0];
            shift_reg_r <= {bus.mosi, shift_reg_r[DATA_W-1:1]};
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!bus.cs) begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miso     = miso_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.overrun  = overrun_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port
//   Drives spi_slave_port through directed frames and a random phase and
//   compares every output after every edge with a word-level reference model
//   (bit counter, accumulated word, queue of buffered transmit words).
module tb_spi_slave_port;

  localparam int         DATA_W = 8;
  localparam logic [7:0] FILL   = 8'h00;

  logic sclk;
  logic reset;

  spi_slave_port_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_port #(.DATA_W(DATA_W), .FILL(FILL)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model state
  bit         m_shift;
  bit         m_done;
  int         m_cnt;
  logic [7:0] m_acc;
  logic [7:0] m_tx;
  logic [7:0] txq[$];
  logic       e_miso;
  logic [7:0] e_rx_data;
  logic       e_rx_valid;
  logic       e_overrun;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shift    = 1'b0;
    m_done     = 1'b0;
    m_cnt      = 0;
    m_acc      = 8'h00;
    m_tx       = 8'h00;
    txq.delete();
    e_miso     = 1'b0;
    e_rx_data  = 8'h00;
    e_rx_valid = 1'b0;
    e_overrun  = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".miso"},     32'(bus.miso),     32'(e_miso));
    check_eq({tag, ".rx_data"},  32'(bus.rx_data),  32'(e_rx_data));
    check_eq({tag, ".rx_valid"}, 32'(bus.rx_valid), 32'(e_rx_valid));
    check_eq({tag, ".overrun"},  32'(bus.overrun),  32'(e_overrun));
    check_eq({tag, ".tx_ready"}, 32'(bus.tx_ready), 32'(txq.size() == 0));
    check_eq({tag, ".busy"},     32'(bus.busy),     32'(m_shift || m_done));
  endtask

  // One rising edge of the reference model, from the inputs applied before it.
  task automatic model_edge(input logic c, input logic e, input logic m,
                            input logic l, input logic [7:0] d, input logic a);
    bit start;
    start     = !c && !m_shift;
    e_overrun = 1'b0;
    if (m_done) begin
      e_overrun  = e_rx_valid && !a;
      e_rx_data  = m_acc;
      e_rx_valid = 1'b1;
    end else if (e_rx_valid && a) begin
      e_rx_valid = 1'b0;
    end
    if (start) begin
      if (txq.size() > 0) begin
        m_tx = txq.pop_front();
      end else begin
        m_tx = FILL;
        if (l) txq.push_back(d);
      end
    end else if (l && txq.size() == 0) begin
      txq.push_back(d);
    end
    if (m_shift) begin
      if (c) begin
        m_shift = 1'b0;
      end else if (e) begin
        e_miso = m_tx[m_cnt];
        m_acc  = m_acc | (8'(m) << m_cnt);
        m_cnt++;
        if (m_cnt == DATA_W) begin
          m_shift = 1'b0;
          m_done  = 1'b1;
        end
      end
    end else if (start) begin
      m_shift = 1'b1;
      m_done  = 1'b0;
      m_cnt   = 0;
      m_acc   = 8'h00;
    end else begin
      m_done = 1'b0;
    end
  endtask

  // Apply inputs after a falling edge, advance one rising edge, then check.
  task automatic step(input logic c, input logic e, input logic m,
                      input logic l, input logic [7:0] d, input logic a);
    bus.cs       = c;
    bus.shift_en = e;
    bus.mosi     = m;
    bus.tx_load  = l;
    bus.tx_data  = d;
    bus.rx_ack   = a;
    @(posedge sclk);
    model_edge(c, e, m, l, d, a);
    @(negedge sclk);
    compare_all("edge");
  endtask

  // Start a frame if not already shifting, then shift one word LSB-first.
  task automatic send_frame(input logic [7:0] word, input bit gappy,
                            input logic ld, input logic [7:0] ld_data);
    int i;
    logic en;
    if (!m_shift) step(1'b0, 1'b0, 1'b0, ld, ld_data, 1'b0);
    i = 0;
    while (i < DATA_W) begin
      en = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, en, word[i], 1'b0, 8'h00, 1'b0);
      if (en) i++;
    end
  endtask

  task automatic idle_cycle(input logic a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
  endtask

  initial begin
    bus.cs = 1'b1; bus.shift_en = 1'b0; bus.mosi = 1'b0;
    bus.tx_load = 1'b0; bus.tx_data = 8'h00; bus.rx_ack = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge sclk);
    compare_all("reset");
    reset = 1'b1;
    idle_cycle(1'b0);

    // reset in the middle of a frame after three bits
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("midrst_async");
    @(negedge sclk);
    compare_all("midrst_held");
    reset = 1'b1;
    idle_cycle(1'b0);

    // buffered 0x3C out, 0xA5 in
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    idle_cycle(1'b0);
    check_eq("frame_a5", 32'(bus.rx_data), 32'h000000A5);
    idle_cycle(1'b1);

    // back-to-back frames without ack -> overrun in second DONE
    send_frame(8'h11, 1'b0, 1'b0, 8'h00);
    send_frame(8'h22, 1'b0, 1'b0, 8'h00);
    idle_cycle(1'b0);
    check_eq("b2b_ovr", 32'(bus.overrun), 32'h1);
    idle_cycle(1'b1);
    check_eq("b2b_ack", 32'(bus.rx_valid), 32'h0);

    // abort after five bits, then a clean frame
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'(i & 1), 1'b0, 8'h00, 1'b0);
    idle_cycle(1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 8'h00);
    idle_cycle(1'b0);
    check_eq("after_abort", 32'(bus.rx_data), 32'h0000005A);

    // load on the frame-start edge with an empty buffer
    send_frame(8'hC3, 1'b0, 1'b1, 8'h81);
    send_frame(8'h3C, 1'b0, 1'b0, 8'h00);
    idle_cycle(1'b1);

    // gaps in shift_en
    send_frame(8'h96, 1'b1, 1'b1, 8'h47);
    idle_cycle(1'b0);
    check_eq("gappy", 32'(bus.rx_data), 32'h00000096);

    // random phase
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
